dmem_access_unit: RTL

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_byte_lane.sv | 39 +++
 rtl/dmem_access_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: access size codes, FSM states, default memory size.
package dmem_pkg;

  localparam logic [31:0] MEM_SIZE_DEF = 32'h0800;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_WALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2:0] access_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: access_bytes = 3'd1;
      SZ_HALF: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core request/response plus memory strobe bundle for dmem_access_unit.
interface dmem_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_read_data,
    input  busy, done, err, rdata, mem_address, mem_write_data, mem_write, mem_read
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_read_data,
    output busy, done, err, rdata, mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/dmem_byte_lane.sv
// Big-endian lane logic: sub-word load extraction/extension and read-modify-write merge.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // offset 0 lives in the most significant byte
    lane      = 2'd3 - offset;
    byte_v    = rd_word[{lane, 3'b000} +: 8];
    half_v    = offset[1] ? rd_word[15:0] : rd_word[31:16];
    load_data = rd_word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged    = rd_word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_v[15]}}, half_v};
        merged    = offset[1] ? {rd_word[31:16], wdata[15:0]} : {wdata[15:0], rd_word[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store FSM between core and a word-wide memory; sub-word stores do read-modify-write.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of ignoring low bits.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEF
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  state_e      state_q, state_d;
  logic        we_q, we_d, sx_q, sx_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        mrd_q, mrd_d, mwr_q, mwr_d;
  logic [31:0] load_data, merged;
  logic        is_word, out_of_range, misalign, reject;

  dmem_byte_lane u_lane (
    .size      (size_q),
    .offset    (off_q),
    .sign_ext  (sx_q),
    .rd_word   (bus.mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    is_word      = bus.size[1];
    out_of_range = ({1'b0, bus.addr} + {30'b0, access_bytes(bus.size)}) > {1'b0, MEM_SIZE};
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign     = ((bus.size == SZ_HALF) && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
`else
    misalign     = 1'b0;
`endif
    reject       = out_of_range | misalign;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sx_d     = sx_q;
    size_d   = size_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.req) begin
        we_d    = bus.we;
        sx_d    = bus.sign_ext;
        size_d  = bus.size;
        off_d   = bus.addr[1:0];
        wdata_d = bus.wdata;
        maddr_d = {bus.addr[31:2], 2'b00};
        if (reject) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (bus.we && is_word) begin
          state_d  = ST_WRITE;
          mwr_d    = 1'b1;
          mwdata_d = bus.wdata;
        end else begin
          state_d = ST_READ;
          mrd_d   = 1'b1;
        end
      end
      ST_READ: begin
        // read word is sampled here for both loads and the merge of sub-word stores
        if (we_q) begin
          state_d  = ST_WRITE;
          mwr_d    = 1'b1;
          mwdata_d = merged;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rdata_d = load_data;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      sx_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sx_q     <= sx_d;
      size_q   <= size_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.mem_address    = maddr_q;
  assign bus.mem_write_data = mwdata_q;
  assign bus.mem_read       = mrd_q;
  assign bus.mem_write      = mwr_q;

endmodule
